// File: rtl/lstm_pkg.sv
// lstm_pkg: default widths, lane data type and fixed-point helpers for the LSTM element-wise stage.
// LSTM_SATURATE_EN makes fx_fit clamp to the DATA_W range instead of two's-complement wrapping.
`default_nettype none

package lstm_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_FRAC_W = 8;

   typedef logic signed [DEF_DATA_W-1:0] lane_data_t;

   // Fit a wide signed value into dw bits (clamp or wrap).
   function automatic longint fx_fit(input longint v, input int dw);
`ifdef LSTM_SATURATE_EN
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (dw - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
`else
      return (v <<< (64 - dw)) >>> (64 - dw);
`endif
   endfunction

   // Full product, keep bits [fw+dw-1:fw].
   function automatic longint fx_mul(input longint a, input longint b, input int dw, input int fw);
      return fx_fit((a * b) >>> fw, dw);
   endfunction

   function automatic longint fx_add(input longint a, input longint b, input int dw);
      return fx_fit(a + b, dw);
   endfunction

   // Piecewise-linear sigmoid: clamp(x/4 + 0.5, 0, 1).
   function automatic longint hard_sigmoid(input longint x, input int fw);
      longint one;
      longint y;
      one = longint'(1) <<< fw;
      y   = (x >>> 2) + (one >>> 1);
      if (y > one) return one;
      if (y < 0) return 0;
      return y;
   endfunction

   // Piecewise-linear tanh: clamp(x, -1, 1).
   function automatic longint hard_tanh(input longint x, input int fw);
      longint one;
      one = longint'(1) <<< fw;
      if (x > one) return one;
      if (x < -one) return -one;
      return x;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lstm_lane.sv
// lstm_lane: one element of the LSTM update, c = s(i)*tanh(g) + s(f)*c_prev, h = s(o)*tanh(c),
// as free-running fixed-latency pipelines with alignment delays.
`default_nettype none

module lstm_lane
   import lstm_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int FRAC_W   = DEF_FRAC_W,
   parameter int ACT_LAT  = 5,
   parameter int MULT_LAT = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] gate_i,
   input  logic signed [DATA_W-1:0] gate_g,
   input  logic signed [DATA_W-1:0] gate_f,
   input  logic signed [DATA_W-1:0] gate_o,
   input  logic signed [DATA_W-1:0] c_prev,
   output logic signed [DATA_W-1:0] c_new,
   output logic signed [DATA_W-1:0] h,
   output logic signed [DATA_W-1:0] c_out
);

   typedef logic signed [DATA_W-1:0] word_t;

   // s(o) waits through stages B, C and D; c_t waits through D and E.
   localparam int SO_LAT = ACT_LAT + MULT_LAT + 1;
   localparam int CD_LAT = ACT_LAT + MULT_LAT;

   word_t si_q [ACT_LAT];
   word_t tg_q [ACT_LAT];
   word_t sf_q [ACT_LAT];
   word_t so_q [ACT_LAT];
   word_t cp_q [ACT_LAT];
   word_t tc_q [ACT_LAT];
   word_t p1_q [MULT_LAT];
   word_t p2_q [MULT_LAT];
   word_t h_q  [MULT_LAT];
   word_t od_q [SO_LAT];
   word_t cd_q [CD_LAT];
   word_t c_q;

   function automatic word_t to_word(input longint v);
      return word_t'(v);
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < ACT_LAT; k++) begin
            si_q[k] <= '0;
            tg_q[k] <= '0;
            sf_q[k] <= '0;
            so_q[k] <= '0;
            cp_q[k] <= '0;
            tc_q[k] <= '0;
         end
         for (int k = 0; k < MULT_LAT; k++) begin
            p1_q[k] <= '0;
            p2_q[k] <= '0;
            h_q[k]  <= '0;
         end
         for (int k = 0; k < SO_LAT; k++) od_q[k] <= '0;
         for (int k = 0; k < CD_LAT; k++) cd_q[k] <= '0;
         c_q <= '0;
      end else begin
         si_q[0] <= to_word(hard_sigmoid(longint'(gate_i), FRAC_W));
         tg_q[0] <= to_word(hard_tanh(longint'(gate_g), FRAC_W));
         sf_q[0] <= to_word(hard_sigmoid(longint'(gate_f), FRAC_W));
         so_q[0] <= to_word(hard_sigmoid(longint'(gate_o), FRAC_W));
         cp_q[0] <= c_prev;
         p1_q[0] <= to_word(fx_mul(longint'(si_q[ACT_LAT-1]), longint'(tg_q[ACT_LAT-1]), DATA_W, FRAC_W));
         p2_q[0] <= to_word(fx_mul(longint'(sf_q[ACT_LAT-1]), longint'(cp_q[ACT_LAT-1]), DATA_W, FRAC_W));
         c_q     <= to_word(fx_add(longint'(p1_q[MULT_LAT-1]), longint'(p2_q[MULT_LAT-1]), DATA_W));
         tc_q[0] <= to_word(hard_tanh(longint'(c_q), FRAC_W));
         od_q[0] <= so_q[ACT_LAT-1];
         h_q[0]  <= to_word(fx_mul(longint'(od_q[SO_LAT-1]), longint'(tc_q[ACT_LAT-1]), DATA_W, FRAC_W));
         cd_q[0] <= c_q;
         for (int k = 1; k < ACT_LAT; k++) begin
            si_q[k] <= si_q[k-1];
            tg_q[k] <= tg_q[k-1];
            sf_q[k] <= sf_q[k-1];
            so_q[k] <= so_q[k-1];
            cp_q[k] <= cp_q[k-1];
            tc_q[k] <= tc_q[k-1];
         end
         for (int k = 1; k < MULT_LAT; k++) begin
            p1_q[k] <= p1_q[k-1];
            p2_q[k] <= p2_q[k-1];
            h_q[k]  <= h_q[k-1];
         end
         for (int k = 1; k < SO_LAT; k++) od_q[k] <= od_q[k-1];
         for (int k = 1; k < CD_LAT; k++) cd_q[k] <= cd_q[k-1];
      end
   end

   assign c_new = c_q;
   assign h     = h_q[MULT_LAT-1];
   assign c_out = cd_q[CD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/lstm_cell_update.sv
// lstm_cell_update: lane-parallel LSTM element-wise stage with cell-state store and RAW hazard stall.
// Optional macro LSTM_SATURATE_EN: clamp additions and product truncations instead of wrapping.
`default_nettype none

module lstm_cell_update
   import lstm_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int FRAC_W   = DEF_FRAC_W,
   parameter  int LANES    = 4,
   parameter  int DEPTH    = 16,
   parameter  int ACT_LAT  = 5,
   parameter  int MULT_LAT = 4,
   localparam int IDX_W    = $clog2(DEPTH),
   localparam int VEC_W    = LANES * DATA_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic [VEC_W-1:0] in_gate_i,
   input  logic [VEC_W-1:0] in_gate_g,
   input  logic [VEC_W-1:0] in_gate_f,
   input  logic [VEC_W-1:0] in_gate_o,
   input  logic             clear_state,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic [VEC_W-1:0] out_h,
   output logic [VEC_W-1:0] out_c
);

   localparam int WB_STAGE  = ACT_LAT + MULT_LAT + 1;
   localparam int OUT_STAGE = 2 * ACT_LAT + 2 * MULT_LAT + 1;

   logic [VEC_W-1:0]     store [DEPTH];
   logic [DEPTH-1:0]     entry_valid;
   logic [OUT_STAGE-1:0] vld_q;
   logic [IDX_W-1:0]     idx_q [OUT_STAGE];
   logic [VEC_W-1:0]     c_prev;
   logic [VEC_W-1:0]     c_new;
   logic [VEC_W-1:0]     h_vec;
   logic [VEC_W-1:0]     c_vec;
   logic [VEC_W-1:0]     hold_h;
   logic [VEC_W-1:0]     hold_c;
   logic [IDX_W-1:0]     hold_idx;
   logic                 hazard;
   logic                 accept;
   logic                 wb_valid;
   logic [IDX_W-1:0]     wb_idx;

   // Stall while an op to the same entry sits anywhere before its writeback.
   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < WB_STAGE; k++) begin
         if (vld_q[k] && (idx_q[k] == in_idx)) hazard = 1'b1;
      end
   end

   assign in_ready = ~hazard;
   assign accept   = in_valid & in_ready;
   assign c_prev   = (entry_valid[in_idx] && !clear_state) ? store[in_idx] : '0;
   assign wb_valid = vld_q[WB_STAGE-1];
   assign wb_idx   = idx_q[WB_STAGE-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
         for (int k = 0; k < OUT_STAGE; k++) idx_q[k] <= '0;
      end else begin
         vld_q    <= {vld_q[OUT_STAGE-2:0], accept};
         idx_q[0] <= in_idx;
         for (int k = 1; k < OUT_STAGE; k++) idx_q[k] <= idx_q[k-1];
      end
   end

   // A writeback landing on the same edge as a clear keeps its entry valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         entry_valid <= '0;
      end else begin
         if (clear_state) entry_valid <= '0;
         if (wb_valid) entry_valid[wb_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && wb_valid) store[wb_idx] <= c_new;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_h   <= '0;
         hold_c   <= '0;
         hold_idx <= '0;
      end else if (vld_q[OUT_STAGE-1]) begin
         hold_h   <= h_vec;
         hold_c   <= c_vec;
         hold_idx <= idx_q[OUT_STAGE-1];
      end
   end

   assign out_valid = vld_q[OUT_STAGE-1];
   assign out_idx   = out_valid ? idx_q[OUT_STAGE-1] : hold_idx;
   assign out_h     = out_valid ? h_vec : hold_h;
   assign out_c     = out_valid ? c_vec : hold_c;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      lstm_lane #(
         .DATA_W   (DATA_W),
         .FRAC_W   (FRAC_W),
         .ACT_LAT  (ACT_LAT),
         .MULT_LAT (MULT_LAT)
      ) u_lane (
         .clock  (clock),
         .reset  (reset),
         .gate_i (in_gate_i[l*DATA_W +: DATA_W]),
         .gate_g (in_gate_g[l*DATA_W +: DATA_W]),
         .gate_f (in_gate_f[l*DATA_W +: DATA_W]),
         .gate_o (in_gate_o[l*DATA_W +: DATA_W]),
         .c_prev (c_prev[l*DATA_W +: DATA_W]),
         .c_new  (c_new[l*DATA_W +: DATA_W]),
         .h      (h_vec[l*DATA_W +: DATA_W]),
         .c_out  (c_vec[l*DATA_W +: DATA_W])
      );
   end

endmodule

`default_nettype wire
